// File: rtl/msi_irq_arbiter.sv
// Edge-triggered MSI request collector with round-robin vector grant and a
// three-state delivery handshake. Define MSI_FAIL_RETRY_EN to retry failed sends.
module msi_irq_arbiter #(
  parameter int MSI_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSI_COUNT-1:0] msi_irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [31:0]          cfg_interrupt_msi_int,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic [15:0]          irq_drop_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state;
  logic [MSI_COUNT-1:0] irq_q, pending, set_vec, clr_vec;
  logic [4:0]           ptr, gnt, nxt, mask;
  logic [2:0]           mm;
  logic [1:0]           retry_cnt;
  logic                 found, grant, unused;

  assign cfg_interrupt_msi_select                      = '0;
  assign cfg_interrupt_msi_pending_status              = '0;
  assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num = '0;
  assign cfg_interrupt_msi_attr                        = '0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = '0;
  assign cfg_interrupt_msi_tph_st_tag                  = '0;
  assign cfg_interrupt_msi_function_number             = '0;
  assign unused = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Multiple-message enable beyond 32 vectors clamps to 32.
  always_comb begin
    mm   = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
    mask = 5'((32'd1 << mm) - 32'd1);
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < MSI_COUNT; i++)
      if (msi_irq[i] && !irq_q[i]) set_vec[i & int'(mask)] = 1'b1;
  end

  // Search starts one past the last granted vector and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    nxt   = '0;
    for (int k = 1; k <= MSI_COUNT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= MSI_COUNT) idx = idx - MSI_COUNT;
      if (!found && pending[idx]) begin
        found = 1'b1;
        nxt   = 5'(idx);
      end
    end
  end

  assign grant   = (state == IDLE) && cfg_interrupt_msi_enable[0] && found;
  assign clr_vec = grant ? (MSI_COUNT'(1) << nxt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      irq_q                 <= '0;
      pending               <= '0;
      ptr                   <= '0;
      gnt                   <= '0;
      retry_cnt             <= '0;
      cfg_interrupt_msi_int <= '0;
      irq_drop_count        <= '0;
    end else begin
      irq_q                 <= msi_irq;
      pending               <= (pending & ~clr_vec) | set_vec;
      cfg_interrupt_msi_int <= '0;
      case (state)
        IDLE: if (grant) begin
          gnt       <= nxt;
          ptr       <= nxt;
          retry_cnt <= '0;
          state     <= ISSUE;
        end
        ISSUE: begin
          cfg_interrupt_msi_int <= 32'd1 << gnt;
          state                 <= WAIT;
        end
        WAIT: if (cfg_interrupt_msi_fail) begin
`ifdef MSI_FAIL_RETRY_EN
          if (retry_cnt != 2'd3) begin
            retry_cnt <= retry_cnt + 2'd1;
            state     <= ISSUE;
          end else begin
            if (irq_drop_count != 16'hFFFF) irq_drop_count <= irq_drop_count + 16'd1;
            state <= IDLE;
          end
`else
          if (irq_drop_count != 16'hFFFF) irq_drop_count <= irq_drop_count + 16'd1;
          state <= IDLE;
`endif
        end else if (cfg_interrupt_msi_sent) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Scenario tasks plus a randomized run scored against a transaction-level
// round-robin model of the arbiter.
module tb_msi_irq_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] msi_irq = '0;
  logic [3:0]  en = '0;
  logic [11:0] mmen = '0;
  logic        sent = 1'b0, fail = 1'b0;
  logic [31:0] msi_int, pend_status;
  logic [3:0]  sel, pfn, fnum;
  logic        pde, tph_present;
  logic [2:0]  attr;
  logic [1:0]  tph_type;
  logic [8:0]  st_tag;
  logic [15:0] drop;

  int checks = 0, failures = 0;

  msi_irq_arbiter #(.MSI_COUNT(32)) dut (
    .clk(clk), .rst(rst), .msi_irq(msi_irq),
    .cfg_interrupt_msi_enable(en), .cfg_interrupt_msi_mmenable(mmen),
    .cfg_interrupt_msi_sent(sent), .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_int(msi_int), .cfg_interrupt_msi_select(sel),
    .cfg_interrupt_msi_pending_status(pend_status),
    .cfg_interrupt_msi_pending_status_data_enable(pde),
    .cfg_interrupt_msi_pending_status_function_num(pfn),
    .cfg_interrupt_msi_attr(attr), .cfg_interrupt_msi_tph_present(tph_present),
    .cfg_interrupt_msi_tph_type(tph_type), .cfg_interrupt_msi_tph_st_tag(st_tag),
    .cfg_interrupt_msi_function_number(fnum), .irq_drop_count(drop)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Advance until an interrupt vector is presented or the bound expires.
  task automatic wait_int(input int limit, output int n);
    n = 0;
    while (msi_int == 32'd0 && n < limit) begin tick(); n++; end
  endtask

  task automatic pulse(input bit f);
    sent = !f; fail = f; tick(); sent = 1'b0; fail = 1'b0;
  endtask

  task automatic do_reset();
    msi_irq = '0; sent = 0; fail = 0; en = 4'h1; mmen = 12'd5;
    rst = 1'b1; tick(2); rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (msi_int !== 32'd0 || drop !== 16'd0) begin
      failures++; $display("FAIL reset: int=%h drop=%0d, want 0/0", msi_int, drop);
    end
    checks++;
    if ({sel, pend_status, pde, pfn, attr, tph_present, tph_type, st_tag, fnum} !== '0) begin
      failures++; $display("FAIL tied_zero: some constant output nonzero");
    end
  endtask

  task automatic test_basic();
    do_reset();
    msi_irq[3] = 1'b1;
    tick();
    checks++;
    if (msi_int !== 32'd0) begin failures++; $display("FAIL basic_e0: int=%h want 0", msi_int); end
    tick();
    checks++;
    if (msi_int !== 32'd0) begin failures++; $display("FAIL basic_e1: int=%h want 0", msi_int); end
    tick();
    checks++;
    if (msi_int !== 32'h8) begin failures++; $display("FAIL basic_e2: int=%h want 8", msi_int); end
    pulse(0);
    checks++;
    if (msi_int !== 32'd0) begin failures++; $display("FAIL basic_width: int=%h want 0", msi_int); end
    msi_irq[3] = 1'b0; tick();
    msi_irq[4] = 1'b1; tick(3);
    checks++;
    if (msi_int !== 32'h10) begin failures++; $display("FAIL basic_idle_again: int=%h want 10", msi_int); end
    pulse(0); msi_irq = '0; tick(2);
  endtask

  task automatic expect_grant(input string name, input logic [31:0] want);
    int n;
    wait_int(12, n);
    checks++;
    if (n >= 12 || msi_int !== want) begin
      failures++; $display("FAIL %s: int=%h want %h (waited %0d)", name, msi_int, want, n);
    end
    pulse(0);
  endtask

  task automatic test_round_robin();
    do_reset();
    msi_irq[1] = 1; msi_irq[5] = 1;
    expect_grant("rr_first", 32'h2);
    expect_grant("rr_second", 32'h20);
    msi_irq = '0; tick(2);
    msi_irq[1] = 1; msi_irq[5] = 1;
    expect_grant("rr_after5_a", 32'h2);
    expect_grant("rr_after5_b", 32'h20);
    msi_irq = '0; tick(2);
    msi_irq[1] = 1;
    expect_grant("rr_single", 32'h2);
    msi_irq = '0; tick(2);
    msi_irq[1] = 1; msi_irq[5] = 1;
    expect_grant("rr_after1_a", 32'h20);
    expect_grant("rr_after1_b", 32'h2);
    msi_irq = '0; tick(2);
  endtask

  task automatic test_fold();
    do_reset();
    mmen = 12'd2; msi_irq[6] = 1;
    expect_grant("fold_mm2", 32'h4);
    msi_irq = '0; tick(2);
    mmen = 12'd7; msi_irq[31] = 1;
    expect_grant("fold_mm7", 32'h8000_0000);
    msi_irq = '0; tick(2);
    mmen = 12'd0; msi_irq[9] = 1;
    expect_grant("fold_mm0", 32'h1);
    msi_irq = '0; mmen = 12'd5; tick(2);
  endtask

  task automatic test_set_wins();
    int seen;
    do_reset();
    mmen = 12'd0;
    msi_irq[1] = 1; tick();
    msi_irq[2] = 1; tick(2);
    checks++;
    if (msi_int !== 32'h1) begin failures++; $display("FAIL setwins_first: int=%h want 1", msi_int); end
    pulse(0);
    expect_grant("setwins_second", 32'h1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (msi_int != 0) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL level_no_retrigger: ints=%0d want 0", seen); end
    msi_irq = '0; mmen = 12'd5; tick(2);
  endtask

  task automatic test_fail();
    int seen, n;
    do_reset();
    msi_irq[2] = 1;
    wait_int(12, n);
    checks++;
    if (msi_int !== 32'h4) begin failures++; $display("FAIL fail_grant: int=%h want 4", msi_int); end
    pulse(1);
`ifdef MSI_FAIL_RETRY_EN
    for (int r = 0; r < 3; r++) begin
      wait_int(12, n);
      checks++;
      if (msi_int !== 32'h4) begin failures++; $display("FAIL fail_retry%0d: int=%h want 4", r, msi_int); end
      pulse(1);
    end
`endif
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (msi_int != 0) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL fail_no_reissue: ints=%0d want 0", seen); end
    checks++;
    if (drop !== 16'd1) begin failures++; $display("FAIL fail_drop: drop=%0d want 1", drop); end
    msi_irq = '0; tick(2);
  endtask

  task automatic test_enable();
    int seen;
    do_reset();
    en = 4'h0; msi_irq[0] = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (msi_int != 0) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL enable_off: ints=%0d want 0", seen); end
    en = 4'h1; tick();
    checks++;
    if (msi_int !== 32'd0) begin failures++; $display("FAIL enable_e1: int=%h want 0", msi_int); end
    tick();
    checks++;
    if (msi_int !== 32'h1) begin failures++; $display("FAIL enable_e2: int=%h want 1", msi_int); end
    pulse(0); msi_irq = '0; tick(2);
  endtask

  // Expects drop count nonzero on entry so the asynchronous clear is visible.
  task automatic test_reset_wait();
    int n, seen;
    msi_irq[0] = 1;
    wait_int(12, n);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (msi_int !== 32'd0 || drop !== 16'd0) begin
      failures++; $display("FAIL reset_async: int=%h drop=%0d want 0/0", msi_int, drop);
    end
    tick(); msi_irq = '0; rst = 1'b0; tick();
    pulse(0); pulse(1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (msi_int != 0) seen++; end
    checks++;
    if (seen != 0 || drop !== 16'd0) begin
      failures++; $display("FAIL reset_stale_resp: ints=%0d drop=%0d want 0/0", seen, drop);
    end
  endtask

  task automatic test_random();
    int mptr, mdrop, eff, v, n;
    logic [31:0] lines, expset, mask;
    bit f;
    do_reset();
    mptr = 0; mdrop = 0;
    for (int r = 0; r < 40; r++) begin
      mmen  = 12'($urandom_range(0, 7));
      lines = $urandom;
      if (lines == 0) lines[r % 32] = 1'b1;
      eff    = (mmen[2:0] > 3'd5) ? 5 : int'(mmen[2:0]);
      mask   = (32'd1 << eff) - 32'd1;
      expset = '0;
      for (int i = 0; i < 32; i++) if (lines[i]) expset[i & int'(mask)] = 1'b1;
      msi_irq = lines;
      while (expset != 0) begin
        v = -1;
        for (int k = 1; k <= 32 && v < 0; k++) if (expset[(mptr + k) % 32]) v = (mptr + k) % 32;
        wait_int(12, n);
        checks++;
        if (n >= 12 || msi_int !== (32'd1 << v)) begin
          failures++; $display("FAIL random_r%0d: int=%h want %h", r, msi_int, 32'd1 << v);
        end
`ifdef MSI_FAIL_RETRY_EN
        f = 1'b0;
`else
        f = ($urandom_range(0, 3) == 0);
`endif
        pulse(f);
        if (f) mdrop++;
        mptr = v;
        expset[v] = 1'b0;
      end
      msi_irq = '0; tick(2);
      checks++;
      if (drop !== 16'(mdrop) || msi_int !== 32'd0) begin
        failures++; $display("FAIL random_end_r%0d: drop=%0d int=%h want %0d/0", r, drop, msi_int, mdrop);
      end
    end
    mmen = 12'd5;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_fold();
    test_set_wins();
    test_enable();
    test_fail();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/msi_irq_arbiter.md
MSI_IRQ_ARBITER -- requirements
Module: msi_irq_arbiter

Interface
- REQ-001 SHALL have parameter MSI_COUNT, default 32: number of interrupt request inputs, range 1..32.
- REQ-002 SHALL have port clk, input, 1: single clock, the PCIe user clock.
- REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
- REQ-004 SHALL have port msi_irq, input, MSI_COUNT: interrupt requests, rising-edge sensitive.
- REQ-005 SHALL have port cfg_interrupt_msi_enable, input, 4: per-function MSI enable; only bit 0 is used.
- REQ-006 SHALL have port cfg_interrupt_msi_mmenable, input, 12: multiple-message enable; only bits 2:0 are used.
- REQ-007 SHALL have port cfg_interrupt_msi_sent, input, 1: single-cycle delivery success pulse.
- REQ-008 SHALL have port cfg_interrupt_msi_fail, input, 1: single-cycle delivery failure pulse.
- REQ-009 SHALL have port cfg_interrupt_msi_int, output, 32: one-hot vector request, asserted for one cycle.
- REQ-010 SHALL have outputs tied to constant zero: cfg_interrupt_msi_select (4), cfg_interrupt_msi_pending_status (32), cfg_interrupt_msi_pending_status_data_enable (1), cfg_interrupt_msi_pending_status_function_num (4), cfg_interrupt_msi_attr (3), cfg_interrupt_msi_tph_present (1), cfg_interrupt_msi_tph_type (2), cfg_interrupt_msi_tph_st_tag (9), cfg_interrupt_msi_function_number (4).
- REQ-011 SHALL have port irq_drop_count, output, 16: saturating count of dropped interrupts.

Function
- REQ-012 SHALL register msi_irq and set pending[i] on the edge where msi_irq[i]=1 and the previous sample was 0; level-high without a new edge sets nothing.
- REQ-013 SHALL fold each vector to i & ((1<<mmenable[2:0])-1), with mmenable values above 5 treated as 5; folded vectors share a pending bit.
- REQ-014 SHALL implement the FSM states IDLE, ISSUE, and WAIT.
- REQ-015 SHALL, in IDLE with enable[0]=1 and pending nonzero, grant round-robin starting at the vector after the last grant, clear that pending bit, and go to ISSUE.
- REQ-016 SHALL, in ISSUE, drive cfg_interrupt_msi_int one-hot to the granted vector for exactly one cycle, then go to WAIT.
- REQ-017 SHALL, in WAIT, return to IDLE on sent; on fail, apply the rule in REQ-023/REQ-024 and return to IDLE.
- REQ-018 SHALL, when sent and fail are both asserted in one cycle, treat it as fail.
- REQ-019 SHALL ignore sent and fail outside WAIT.
- REQ-020 SHALL give a latency of 2 clk edges from the sampling edge of a rising msi_irq to cfg_interrupt_msi_int, when idle and enabled.
- REQ-021 SHALL, when a new edge for vector i coincides with the clearing of pending[i], leave pending[i] set (set wins).
- REQ-022 SHALL, when enable[0]=0, retain pending bits and start no grant; a transaction already in WAIT still completes.

Reset
- REQ-025 SHALL, on asserted rst, immediately force FSM=IDLE, pending=0, the msi_irq sample register=0, the round-robin pointer=0, cfg_interrupt_msi_int=0, irq_drop_count=0, and the retry count=0.
- REQ-026 SHALL abandon any in-flight request on reset mid-WAIT, and ignore later sent/fail for it.

Configuration
- REQ-023 SHALL, with MSI_FAIL_RETRY_EN defined, re-issue a failed vector (return to ISSUE) up to 3 retries, then drop it and increment irq_drop_count.
- REQ-024 SHALL, without MSI_FAIL_RETRY_EN, drop a failed vector immediately and increment irq_drop_count, saturating at 16'hFFFF.

Verification
- REQ-027 SHALL cover: msi_irq[3] rises, enable=1, mmenable=5 -> int=32'h8 exactly 2 edges later for 1 cycle; sent -> IDLE.
- REQ-028 SHALL cover: msi_irq[1] and msi_irq[5] rise together -> int=32'h2, then after sent int=32'h20; a second pair grants 5 before 1 only if the last grant was 1.
- REQ-029 SHALL cover: mmenable=2 and msi_irq[6] rises -> int=32'h4 (6&3=2).
- REQ-030 SHALL cover: fail pulse -> without the macro irq_drop_count=1 and no reissue; with the macro int is reissued 3 times, then irq_drop_count=1.
- REQ-031 SHALL cover: enable=0 while msi_irq[0] rises -> no int; enable set to 1 -> int=32'h1 2 edges later.
- REQ-032 SHALL cover: rst asserted in WAIT -> all outputs 0 asynchronously; a subsequent sent pulse has no effect.
